// File: rtl/ps2_scancode_decoder.sv
// ps2_scancode_decoder: Set-2 prefix decoder with repeat filter, prefix timeout and FWFT event FIFO
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH    = 4,
  parameter int FILTER_REPEAT = 1,
  parameter int REPORT_MAKE   = 1,
  parameter int TIMEOUT_CYC   = 1000000
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ready,
  input  logic [7:0]                    datain,
  input  logic                          rd_en,
  input  logic                          clr_ovf,
  output logic [7:0]                    ev_code,
  output logic                          ev_ext,
  output logic                          ev_break,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic [1:0]                    state_dbg
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYC - 1);
  // bit0 of the state means "E0 seen", bit1 means "F0 seen"
  typedef enum logic [1:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0} state_t;
  state_t state, state_nx;
  logic ready_d, rise, tmo, status, ev_v, ev_b, ev_e;
  logic match, make, brk, keep, push, pop, wr;
  logic [TW-1:0] tcnt;
  logic rep_v, rep_e;
  logic [7:0] rep_c;
  logic [9:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt;
  assign rise   = ready & ~ready_d;
  assign tmo    = (state != IDLE) && (tcnt == TMAX);
  assign status = datain inside {8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF};
  always_comb begin
    state_nx = state;
    ev_v = 1'b0;
    ev_b = state[1];
    ev_e = state[0];
    if (rise) begin
      if (datain == 8'hE0) state_nx = state_t'({state[1], 1'b1});
      else if (datain == 8'hF0) state_nx = state_t'({1'b1, state[0]});
      else begin
        state_nx = IDLE;
        ev_v = !(state == IDLE && status);
      end
    end else if (tmo) state_nx = IDLE;
  end
  assign match = rep_v && ({rep_e, rep_c} == {ev_e, datain});
  assign make  = ev_v & ~ev_b;
  assign brk   = ev_v & ev_b;
  assign keep  = make & ~((FILTER_REPEAT != 0) && match);
  assign push  = (keep && (REPORT_MAKE != 0)) | brk;
  assign empty = cnt == '0;
  assign full  = cnt == (AW+1)'(FIFO_DEPTH);
  assign pop   = rd_en & ~empty;
  assign wr    = push & (~full | pop);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state   <= IDLE;
      ready_d <= 1'b0;
      tcnt    <= '0;
      rep_v   <= 1'b0;
      rep_e   <= 1'b0;
      rep_c   <= '0;
      wp      <= '0;
      rp      <= '0;
      cnt     <= '0;
      overflow <= 1'b0;
    end else begin
      state   <= state_nx;
      ready_d <= ready;
      tcnt    <= (rise || state_nx == IDLE) ? '0 : tcnt + TW'(1);
      if (keep) {rep_v, rep_e, rep_c} <= {1'b1, ev_e, datain};
      else if (brk && match) rep_v <= 1'b0;
      if (wr) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      cnt <= cnt + (AW+1)'(wr) - (AW+1)'(pop);
      if (push && full && !pop) overflow <= 1'b1;
      else if (clr_ovf) overflow <= 1'b0;
    end
  always_ff @(posedge clk)
    if (wr) mem[wp] <= {ev_e, ev_b, datain};
  assign {ev_ext, ev_break, ev_code} = empty ? 10'd0 : mem[rp];
  assign count     = cnt;
  assign state_dbg = state;
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb_ps2_scancode_decoder: directed checks of decoding, filtering, timeout, FIFO and async reset
module tb_ps2_scancode_decoder;
  logic clk = 0, reset = 0, ready = 0, clr_ovf = 0, rd0 = 0, rd1 = 0;
  logic [7:0] datain = 0;
  logic [7:0] code0, code1;
  logic ext0, ext1, brk0, brk1, empty0, empty1, full0, full1, ovf0, ovf1;
  logic [2:0] count0;
  logic [3:0] count1;
  logic [1:0] st0, st1;
  int n = 0, fails = 0;
  always #5 clk = ~clk;
  ps2_scancode_decoder #(.FIFO_DEPTH(4), .FILTER_REPEAT(1), .TIMEOUT_CYC(8)) u0 (
    .clk(clk), .reset(reset), .ready(ready), .datain(datain), .rd_en(rd0), .clr_ovf(clr_ovf),
    .ev_code(code0), .ev_ext(ext0), .ev_break(brk0), .empty(empty0), .full(full0),
    .count(count0), .overflow(ovf0), .state_dbg(st0));
  ps2_scancode_decoder #(.FIFO_DEPTH(8), .FILTER_REPEAT(0), .TIMEOUT_CYC(8)) u1 (
    .clk(clk), .reset(reset), .ready(ready), .datain(datain), .rd_en(rd1), .clr_ovf(clr_ovf),
    .ev_code(code1), .ev_ext(ext1), .ev_break(brk1), .empty(empty1), .full(full1),
    .count(count1), .overflow(ovf1), .state_dbg(st1));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] h0();
    return {22'd0, ext0, brk0, code0};
  endfunction
  function automatic logic [31:0] h1();
    return {22'd0, ext1, brk1, code1};
  endfunction
  task automatic send(input logic [7:0] b);
    @(negedge clk) begin datain = b; ready = 1; end
    @(negedge clk) ready = 0;
  endtask
  task automatic pop(input int which);
    @(negedge clk) if (which == 0) rd0 = 1; else rd1 = 1;
    @(negedge clk) begin rd0 = 0; rd1 = 0; end
  endtask
  task automatic do_reset();
    @(negedge clk) reset = 0;
    @(negedge clk) reset = 1;
    @(negedge clk);
  endtask
  task automatic idle(input int c);
    repeat (c) @(negedge clk);
  endtask
  initial begin
    idle(2);
    check("rst_empty", empty0, 1);
    check("rst_full", full0, 0);
    check("rst_count", count0, 0);
    check("rst_ovf", ovf0, 0);
    check("rst_head", h0(), 0);
    check("rst_state", st0, 0);
    reset = 1;
    idle(1);
    send(8'h1C); send(8'hF0); send(8'h1C);
    check("mb_count", count0, 2);
    check("mb_head0", h0(), 10'h01C);
    pop(0);
    check("mb_head1", h0(), 10'h11C);
    pop(0);
    check("mb_empty", empty0, 1);
    send(8'hE0);
    check("e0_state", st0, 1);
    send(8'h75);
    check("e0m_state", st0, 0);
    send(8'hE0); send(8'hF0);
    check("e0f0_state", st0, 3);
    send(8'h75);
    check("e0b_state", st0, 0);
    check("ext_head0", h0(), 10'h275);
    pop(0);
    check("ext_head1", h0(), 10'h375);
    pop(0);
    do_reset();
    send(8'h1C); send(8'h1C); send(8'h1C); send(8'hF0); send(8'h1C); send(8'h1C);
    check("flt_count", count0, 3);
    check("flt_h0", h0(), 10'h01C); pop(0);
    check("flt_h1", h0(), 10'h11C); pop(0);
    check("flt_h2", h0(), 10'h01C); pop(0);
    check("flt_empty", empty0, 1);
    check("nof_count", count1, 5);
    check("nof_h0", h1(), 10'h01C); pop(1);
    check("nof_h1", h1(), 10'h01C); pop(1);
    check("nof_h2", h1(), 10'h01C); pop(1);
    check("nof_h3", h1(), 10'h11C); pop(1);
    check("nof_h4", h1(), 10'h01C); pop(1);
    check("nof_empty", empty1, 1);
    do_reset();
    send(8'hF0);
    idle(7);
    check("tmo_hold", st0, 2);
    idle(1);
    check("tmo_idle", st0, 0);
    idle(2);
    send(8'h1C);
    check("tmo_count", count0, 1);
    check("tmo_head", h0(), 10'h01C);
    send(8'hAA); send(8'hFA);
    check("status_drop", count0, 1);
    pop(0);
    do_reset();
    send(8'h15); send(8'h1D); send(8'h24); send(8'h2D);
    check("fill_ovf", ovf0, 0);
    send(8'h2C);
    check("ovf_full", full0, 1);
    check("ovf_set", ovf0, 1);
    check("ovf_head", h0(), 10'h015);
    @(negedge clk) begin datain = 8'h1B; ready = 1; rd0 = 1; end
    @(negedge clk) begin ready = 0; rd0 = 0; end
    check("pp_count", count0, 4);
    check("pp_ovf", ovf0, 1);
    check("pp_head", h0(), 10'h01D);
    @(negedge clk) clr_ovf = 1;
    @(negedge clk) clr_ovf = 0;
    check("clr_ovf", ovf0, 0);
    pop(0); pop(0); pop(0);
    check("pp_last", h0(), 10'h01B);
    do_reset();
    send(8'h1C); send(8'h32); send(8'hE0); send(8'hF0);
    check("pre_state", st0, 3);
    check("pre_count", count0, 2);
    @(negedge clk) #2 reset = 0;
    #1;
    check("arst_empty", empty0, 1);
    check("arst_count", count0, 0);
    check("arst_state", st0, 0);
    check("arst_ovf", ovf0, 0);
    check("arst_head", h0(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n, fails);
    $finish;
  end
endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
- Parametrised successor to the single-state break-code catcher.
- Consumes bytes from the PS/2 byte receiver and decodes Set-2 prefix sequences: plain make, E0 make, F0 break and E0 F0 break.
- Filters typematic repeats and device-status bytes, and times out stalled prefixes.
- Buffers decoded key events in a first-word-fall-through FIFO read by the display/control logic.

Parameters:
- FIFO_DEPTH, 4: event FIFO entries; must be a power of 2, at least 2.
- FILTER_REPEAT, 1: when 1, a make event identical to the last un-released make is suppressed.
- REPORT_MAKE, 1: when 0, only break events are pushed, matching legacy behaviour.
- TIMEOUT_CYC, 1000000: idle clocks in a prefix state before the FSM abandons the sequence; minimum 2.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset.
- ready, input, 1: byte-valid level from the receiver, synchronous to clk; each rising edge carries one byte.
- datain, input, 8: received byte, stable while ready is high.
- rd_en, input, 1: pop the FIFO head; ignored when empty.
- clr_ovf, input, 1: clears overflow.
- ev_code, output, 8: head event scancode.
- ev_ext, output, 1: head event had the E0 prefix.
- ev_break, output, 1: head event is a release.
- empty, output, 1: FIFO empty.
- full, output, 1: FIFO full.
- count, output, clog2(FIFO_DEPTH)+1: FIFO occupancy.
- overflow, output, 1: sticky flag; an event was dropped because the FIFO was full.
- state_dbg, output, 2: current FSM state, for simulation and LEDs.

Behaviour:
- Reset values (reset=0, asynchronous):
  - FSM goes to IDLE; ready_d=0; timeout counter=0.
  - FIFO pointers=0; empty=1, full=0, count=0.
  - overflow=0; ev_code=0x00, ev_ext=0, ev_break=0.
  - Repeat-filter register is invalid.
- Byte strobe: rise = ready & ~ready_d, where ready_d is a registered copy of ready.
  - Only rise cycles advance the FSM.
  - Holding ready high produces no further bytes.
- State encoding: IDLE=0, GOT_E0=1, GOT_F0=2, GOT_E0F0=3.
- IDLE:
  - E0 goes to GOT_E0; F0 goes to GOT_F0.
  - 0x00, 0xAA, 0xEE, 0xFA, 0xFC, 0xFE, 0xFF are dropped; stay in IDLE.
  - Any other byte produces a make event {ext=0, code}.
- GOT_E0:
  - F0 goes to GOT_E0F0; E0 stays in GOT_E0.
  - Any other byte produces a make event {ext=1, code}, then IDLE.
- GOT_F0:
  - F0 stays in GOT_F0; E0 goes to GOT_E0F0.
  - Any other byte produces a break event {ext=0, code}, then IDLE.
- GOT_E0F0:
  - E0 or F0 stays in GOT_E0F0.
  - Any other byte produces a break event {ext=1, code}, then IDLE.
- Timeout:
  - The counter clears on every rise and on entry to IDLE, and increments in non-IDLE states.
  - Reaching TIMEOUT_CYC-1 forces IDLE with no event, and the counter clears.
  - If rise coincides with the terminal count, rise wins.
- Repeat filter (FILTER_REPEAT=1):
  - A make event equal to the stored {ext, code} with valid=1 is discarded.
  - Otherwise the make is pushed and the register is loaded with valid=1.
  - A break matching the register clears valid.
  - A non-matching break leaves the register unchanged.
  - Filtering is applied before REPORT_MAKE gating.
- FIFO:
  - Entry width is 10 bits: {ext, break, code}.
  - Push occurs on the same clk edge the FSM decodes the terminating byte.
  - The head appears on ev_* and empty falls one cycle after the rise cycle.
  - rd_en with empty=0 advances the head on that edge.
  - Push while full with no pop: event dropped, overflow←1, pointers unchanged.
  - Push and pop in the same cycle while full: both are performed, no overflow, count unchanged.
  - Push and pop in the same cycle while empty: push only.
  - Pointers wrap modulo FIFO_DEPTH; count distinguishes full from empty.
- overflow clears only on clr_ovf=1 or reset. If clr_ovf and a new drop occur in the same cycle, overflow=1.
- Reset mid-sequence discards the partial prefix and all FIFO contents immediately.

Test Plan:
- Bytes 1C, F0 1C (one rise each), FILTER_REPEAT=1 -> FIFO holds {0,0,1C} then {0,1,1C}; count=2; each ev_* value is seen after rd_en.
- Bytes E0 75, E0 F0 75 -> events {1,0,75}, {1,1,75}; state_dbg returns to 0 after each.
- Bytes 1C 1C 1C F0 1C 1C with FILTER_REPEAT=1 -> events make 1C, break 1C, make 1C (count=3). Same stimulus with FILTER_REPEAT=0 -> 5 makes/breaks in order.
- Byte F0 followed by TIMEOUT_CYC idle clocks, then 1C -> no break event; a single make {0,0,1C}. Also: AA and FA in IDLE -> nothing pushed.
- FIFO_DEPTH=4: push 5 makes (15,1D,24,2D,2C) with no reads -> full=1, overflow=1, head=15. Then rd_en coinciding with a push -> count stays 4. Then clr_ovf -> overflow=0.
- Assert reset low asynchronously mid-sequence after E0 F0 with 2 events queued -> empty=1, count=0, state_dbg=0, overflow=0 immediately, without waiting for a clk edge.
